soc_mgmt_rst_seq: RTL

Parametrised reset sequencer for the SoC management block. It is the next generation of the fixed three-stage SoC management reset generator. It chains `NUM_STAGES` reset stages, where each stage is held in reset while its predecessor is in reset, then released after a programmable stretch. Each stage adds unmasked per-stage reset sources, a software reset pulse, a level req/ack handshake with IP-acknowledge timeout, and sticky reset-cause and timeout flags.

---
 rtl/soc_mgmt_rst_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/soc_mgmt_rst_seq.sv
// Chained multi-stage reset sequencer: per-stage source/software/request triggers,
// programmable release stretch, IP-acknowledge handshake with timeout, and sticky cause logging.
module soc_mgmt_rst_seq #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_SRC    = 4,
    parameter int STRETCHW   = 12,
    parameter int ACK_TOW    = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_test_mode,
    input  logic [NUM_STAGES-1:0]                 i_test_rst_n,
    input  logic [NUM_STAGES-1:0][NUM_SRC-1:0]    i_src_rst_n,
    input  logic [NUM_STAGES-1:0][NUM_SRC-1:0]    i_src_mask,
    input  logic [NUM_STAGES-1:0][STRETCHW-1:0]   i_stretch_cycles,
    input  logic [NUM_STAGES-1:0]                 i_sw_rst_req,
    input  logic [NUM_STAGES-1:0]                 i_rst_req_n,
    output logic [NUM_STAGES-1:0]                 o_rst_ack_n,
    input  logic [NUM_STAGES-1:0]                 i_ip_ack,
    output logic [NUM_STAGES-1:0]                 o_stage_rst_n,
    output logic [NUM_STAGES-1:0][NUM_SRC:0]      o_cause,
    input  logic [NUM_STAGES-1:0]                 i_cause_clr,
    output logic [NUM_STAGES-1:0]                 o_ack_timeout
);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_STRETCH  = 2'd1,
        ST_RELEASED = 2'd2
    } state_t;

    localparam logic [STRETCHW:0]  CNT_ONE = (STRETCHW + 1)'(1);
    localparam logic [ACK_TOW-1:0] TO_ONE  = ACK_TOW'(1);

    // Functional (pre-test-mux) stage resets; the chain is always built from these.
    logic [NUM_STAGES-1:0] func_rst_n;

    assign o_stage_rst_n = i_test_mode ? i_test_rst_n : func_rst_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic [NUM_SRC-1:0]  src_hit;
            logic                req_hit;
            logic                upstream_rst;
            logic                trig;
            logic                stay_assert;
            logic                timeout_fire;
            logic                stretch_done;

            state_t              state_q, state_d;
            logic [STRETCHW-1:0] cnt_q, cnt_d;
            logic [ACK_TOW-1:0]  to_cnt_q, to_cnt_d;
            logic                ack_seen_q, ack_seen_d;
            logic                rel_q, rel_d;
            logic                ack_n_q, ack_n_d;
            logic                timeout_q, timeout_d;
            logic [NUM_SRC:0]    cause_q, cause_d;

            if (gi == 0) begin : g_head
                assign upstream_rst = 1'b0;
            end else begin : g_chain
                assign upstream_rst = ~func_rst_n[gi-1];
            end

            assign src_hit = ~i_src_rst_n[gi] & ~i_src_mask[gi];
            assign req_hit = i_sw_rst_req[gi] | ~i_rst_req_n[gi];
            assign trig    = (|src_hit) | req_hit | upstream_rst;

            // Release once count reaches S-1, or immediately if S was lowered beneath it.
            assign stretch_done = ({1'b0, cnt_q} + CNT_ONE) >= {1'b0, i_stretch_cycles[gi]};

            always_comb begin
                state_d = state_q;
                cnt_d   = '0;
                case (state_q)
                    ST_ASSERT: begin
                        if (!trig) begin
                            state_d = (i_stretch_cycles[gi] == '0) ? ST_RELEASED : ST_STRETCH;
                        end
                    end
                    ST_STRETCH: begin
                        if (trig) begin
                            state_d = ST_ASSERT;
                        end else if (stretch_done) begin
                            state_d = ST_RELEASED;
                        end else begin
                            cnt_d = cnt_q + STRETCHW'(1);
                        end
                    end
                    ST_RELEASED: begin
                        if (trig) begin
                            state_d = ST_ASSERT;
                        end
                    end
                    default: state_d = ST_ASSERT;
                endcase
            end

            // Handshake only tracks a stage that is already in ASSERT and remains there.
            always_comb begin
                stay_assert  = (state_q == ST_ASSERT) && (state_d == ST_ASSERT);
                to_cnt_d     = '0;
                timeout_fire = 1'b0;
                if (stay_assert) begin
                    to_cnt_d     = (&to_cnt_q) ? to_cnt_q : (to_cnt_q + TO_ONE);
                    timeout_fire = !(&to_cnt_q) && (&to_cnt_d) && !ack_seen_q && !i_ip_ack[gi];
                end
                ack_seen_d = stay_assert && (ack_seen_q || i_ip_ack[gi] || timeout_fire);
                ack_n_d    = ~ack_seen_d;
                timeout_d  = timeout_q | timeout_fire;
                rel_d      = (state_d == ST_RELEASED);
                cause_d    = (cause_q & ~{(NUM_SRC + 1){i_cause_clr[gi]}}) | {req_hit, src_hit};
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q    <= ST_ASSERT;
                    cnt_q      <= '0;
                    to_cnt_q   <= '0;
                    ack_seen_q <= 1'b0;
                    rel_q      <= 1'b0;
                    ack_n_q    <= 1'b1;
                    timeout_q  <= 1'b0;
                    cause_q    <= '0;
                end else begin
                    state_q    <= state_d;
                    cnt_q      <= cnt_d;
                    to_cnt_q   <= to_cnt_d;
                    ack_seen_q <= ack_seen_d;
                    rel_q      <= rel_d;
                    ack_n_q    <= ack_n_d;
                    timeout_q  <= timeout_d;
                    cause_q    <= cause_d;
                end
            end

            assign func_rst_n[gi]    = rel_q;
            assign o_rst_ack_n[gi]   = ack_n_q;
            assign o_ack_timeout[gi] = timeout_q;
            assign o_cause[gi]       = cause_q;
        end
    endgenerate

endmodule
